hex_display_bank: RTL and testbench
===================================

// Module: hex_display_bank
// PURPOSE
//   Parametrised, registered multi-digit hex-to-7-segment driver with per-digit decimal point.
//   Adds what a single-digit decoder lacks: load strobe, leading-zero blanking, per-digit blink,
//   and an optional time-multiplexed (scanned) output mode.
//   Sits between the reaction-time datapath and the board's HEX displays.
// PARAMETERS
//   NUM_DIGITS  6           number of digits (lanes); 1..8
//   BLINK_DIV   25_000_000  clocks per blink half-period (0.5 s at 50 MHz); >=2
//   SCAN        0           0 = static (one HEX lane per digit); 1 = scanned (lane 0 muxed)
//   SCAN_DIV    50_000      clocks per digit in scanned mode; >=1
// PORTS
//   CLOCK_50   in   1             single clock; all state changes on rising edge
//   RESET_N    in   1             synchronous, active-low reset
//   load       in   1             1 = capture value/dots/blink into shadow regs this edge
//   value      in   4*NUM_DIGITS  nibble i = digit i (digit 0 least significant)
//   dots       in   NUM_DIGITS    1 = decimal point of digit i lit
//   blink      in   NUM_DIGITS    1 = digit i blinks
//   blank_lz   in   1             1 = leading-zero suppression (live, not latched)
//   HEX        out  8*NUM_DIGITS  lane i = {dp,g,f,e,d,c,b,a}, active-low, registered
//   digit_sel  out  NUM_DIGITS    scanned mode: one-hot active-low digit enable; static: all 0
// BEHAVIOUR
//   Reset (RESET_N=0 at an edge): shadow value/dots/blink = 0; HEX all lanes 8'hFF;
//     blink counter = 0; blink phase = on; scan index = 0; scan counter = 0;
//     digit_sel = all 1 (SCAN=1) or all 0 (SCAN=0). Reset overrides load.
//   Load: load=1 at edge k updates the shadow regs at k; HEX reflects them at edge k+1.
//     Between loads, HEX is driven from the shadow regs, not the live inputs.
//   Glyphs (gfedcba, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//     8:00 9:18 A:08 B:03 C:46 D:21 E:06 F:0E. Bit 7 = ~dot.
//   Leading-zero blanking: when blank_lz=1, scan from digit NUM_DIGITS-1 downward;
//     every digit that is 0 and above the highest nonzero digit gets segments 7F.
//     Digit 0 is never blanked. The dot of a blanked digit still follows dots[i].
//   Blink: free-running counter 0..BLINK_DIV-1; phase toggles at terminal count, counter wraps to 0.
//     While phase = off, each digit with blink[i]=1 is fully blank (8'hFF, including dot).
//     Load neither resets nor alters the counter or phase.
//   Scanned mode (SCAN=1): scan counter 0..SCAN_DIV-1; at terminal count the index
//     advances; index NUM_DIGITS-1 wraps to 0. digit_sel[index]=0, all other bits 1.
//     HEX lane 0 = fully processed pattern of digit[index], registered in the same edge
//     as digit_sel. Lanes 1..NUM_DIGITS-1 = 8'hFF.
//   Static mode (SCAN=0): lane i = processed pattern of digit i; scan logic is absent.
//   Priority per lane: blink-off blank > leading-zero blank > glyph decode; dot is applied last.
//   Counter widths: $clog2 of the divider. Counters never exceed DIV-1.
//   Reset mid-blink or mid-scan: all state returns to its reset value on that edge.
//     Normal operation resumes on the first edge with RESET_N=1.
// TESTING
//   1 Hold RESET_N=0 for 3 clk with load=1 -> HEX all 8'hFF, digit_sel=all 1 (SCAN=1),
//     shadow not updated.
//   2 NUM_DIGITS=6, load value=24'h00A3F1, dots=6'b000010, blank_lz=0, blink=0
//     -> at edge k+1: lanes 0..5 = F9,0E,B0,88,C0,C0.
//   3 Same value with blank_lz=1 -> lanes 4,5 = FF, others unchanged.
//     Then load value=0 -> lane 0 = C0, lanes 1..5 = FF.
//   4 BLINK_DIV=4, blink=6'b000001, value digit0=1 -> lane 0 alternates F9/FF every 4 clk.
//     Other lanes stay steady. A load mid-phase leaves the phase cadence unchanged.
//   5 SCAN=1, NUM_DIGITS=4, SCAN_DIV=2, value=16'h4321
//     -> digit_sel 1110,1101,1011,0111 with lane 0 = F9,A4,B0,99; each held for 2 clk.
//     The sequence wraps to 1110.
//   6 Assert RESET_N=0 for 1 clk during scan index 2 and blink phase off
//     -> next edge: HEX all FF, index 0, counters 0. Sequence restarts from digit 0.

Source files
------------

// File: rtl/hex_display_bank.sv
// Registered multi-digit hex-to-7-segment driver with load strobe, leading-zero
// blanking, per-digit blink and optional scanned (time-multiplexed) output.
module hex_display_bank #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25_000_000,
   parameter int SCAN       = 0,
   parameter int SCAN_DIV   = 50_000
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dots,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic                    blank_lz,
   output logic [8*NUM_DIGITS-1:0] HEX,
   output logic [NUM_DIGITS-1:0]   digit_sel
);

   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h18;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   logic [4*NUM_DIGITS-1:0] value_reg;
   logic [NUM_DIGITS-1:0]   dots_reg;
   logic [NUM_DIGITS-1:0]   blink_reg;
   logic [BW-1:0]           blink_cnt_reg, blink_cnt_next;
   logic                    phase_reg, phase_next;
   logic [8*NUM_DIGITS-1:0] pattern;

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         value_reg <= '0;
         dots_reg  <= '0;
         blink_reg <= '0;
      end else if (load) begin
         value_reg <= value;
         dots_reg  <= dots;
         blink_reg <= blink;
      end
   end

   // Blink timebase is free-running; loads never touch it.
   always_comb begin
      blink_cnt_next = blink_cnt_reg + BW'(1);
      phase_next     = phase_reg;
      if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
         blink_cnt_next = '0;
         phase_next     = ~phase_reg;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         blink_cnt_reg <= '0;
         phase_reg     <= 1'b1;
      end else begin
         blink_cnt_reg <= blink_cnt_next;
         phase_reg     <= phase_next;
      end
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
         assign pattern[7:0] = (blink_reg[0] && !phase_reg) ? 8'hFF :
                               {~dots_reg[0], glyph(value_reg[3:0])};
      end else begin : g_upper
         logic lz;
         // Blank when this digit and every digit above it are zero.
         assign lz = blank_lz && (value_reg[4*NUM_DIGITS-1:4*gi] == '0);
         assign pattern[8*gi +: 8] = (blink_reg[gi] && !phase_reg) ? 8'hFF :
                                     {~dots_reg[gi], lz ? 7'h7F : glyph(value_reg[4*gi +: 4])};
      end
   end

   if (SCAN == 0) begin : g_static
      logic [8*NUM_DIGITS-1:0] hex_reg;

      always_ff @(posedge CLOCK_50) begin
         if (!RESET_N) hex_reg <= '1;
         else          hex_reg <= pattern;
      end

      assign HEX       = hex_reg;
      assign digit_sel = '0;
   end else begin : g_scan
      localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
      localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

      logic [SW-1:0]           scan_cnt_reg, scan_cnt_next;
      logic [IW-1:0]           scan_idx_reg, scan_idx_next;
      logic [NUM_DIGITS-1:0]   sel_reg;
      logic [8*NUM_DIGITS-1:0] hex_reg;

      always_comb begin
         scan_cnt_next = scan_cnt_reg + SW'(1);
         scan_idx_next = scan_idx_reg;
         if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
            scan_cnt_next = '0;
            scan_idx_next = (scan_idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_reg + IW'(1);
         end
      end

      // digit_sel and lane 0 both come from the current index so they stay aligned.
      always_ff @(posedge CLOCK_50) begin
         if (!RESET_N) begin
            scan_cnt_reg <= '0;
            scan_idx_reg <= '0;
            sel_reg      <= '1;
            hex_reg      <= '1;
         end else begin
            scan_cnt_reg <= scan_cnt_next;
            scan_idx_reg <= scan_idx_next;
            sel_reg      <= ~(NUM_DIGITS'(1) << scan_idx_reg);
            hex_reg      <= '1;
            hex_reg[7:0] <= pattern[{scan_idx_reg, 3'b000} +: 8];
         end
      end

      assign HEX       = hex_reg;
      assign digit_sel = sel_reg;
   end

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench: a static 6-digit instance and a scanned 4-digit instance on one clock.
module tb_hex_display_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // static instance
   logic        rst_s = 1'b0, load_s = 1'b0, blz_s = 1'b0;
   logic [23:0] value_s = '0;
   logic [5:0]  dots_s = '0, blink_s = '0;
   logic [47:0] hex_s;
   logic [5:0]  sel_s;

   // scanned instance
   logic        rst_m = 1'b0, load_m = 1'b0, blz_m = 1'b0;
   logic [15:0] value_m = '0;
   logic [3:0]  dots_m = '0, blink_m = '0;
   logic [31:0] hex_m;
   logic [3:0]  sel_m;

   hex_display_bank #(.NUM_DIGITS(6), .BLINK_DIV(4), .SCAN(0), .SCAN_DIV(2)) dut_s (
      .CLOCK_50(clk), .RESET_N(rst_s), .load(load_s), .value(value_s), .dots(dots_s),
      .blink(blink_s), .blank_lz(blz_s), .HEX(hex_s), .digit_sel(sel_s));

   hex_display_bank #(.NUM_DIGITS(4), .BLINK_DIV(4), .SCAN(1), .SCAN_DIV(2)) dut_m (
      .CLOCK_50(clk), .RESET_N(rst_m), .load(load_m), .value(value_m), .dots(dots_m),
      .blink(blink_m), .blank_lz(blz_m), .HEX(hex_m), .digit_sel(sel_m));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_s = 1'b0; rst_m = 1'b0;
      load_s = 1'b1; value_s = 24'h123456; dots_s = '1;
      load_m = 1'b1; value_m = 16'hABCD;   dots_m = '1;
      repeat (3) step();
      total++; if (hex_s !== {48{1'b1}}) begin bad++; $display("FAIL reset_hex_static: got %h want all FF", hex_s); end
      total++; if (sel_s !== 6'b000000) begin bad++; $display("FAIL reset_sel_static: got %b want 000000", sel_s); end
      total++; if (hex_m !== {32{1'b1}}) begin bad++; $display("FAIL reset_hex_scan: got %h want all FF", hex_m); end
      total++; if (sel_m !== 4'b1111) begin bad++; $display("FAIL reset_sel_scan: got %b want 1111", sel_m); end
      rst_s = 1'b1; rst_m = 1'b1; load_s = 1'b0; load_m = 1'b0; dots_s = '0; dots_m = '0;
      step(); step();
      total++; if (hex_s !== {6{8'hC0}}) begin bad++; $display("FAIL reset_shadow: got %h want %h", hex_s, {6{8'hC0}}); end
      $display("test_reset done");
   endtask

   task automatic test_decode();
      logic [7:0] exp [6] = '{8'hF9, 8'h0E, 8'hB0, 8'h88, 8'hC0, 8'hC0};
      value_s = 24'h00A3F1; dots_s = 6'b000010; blz_s = 1'b0; blink_s = '0; load_s = 1'b1;
      step();
      load_s = 1'b0;
      total++; if (hex_s !== {6{8'hC0}}) begin bad++; $display("FAIL decode_latency: got %h want %h", hex_s, {6{8'hC0}}); end
      step();
      for (int i = 0; i < 6; i++) begin
         total++;
         if (hex_s[8*i +: 8] !== exp[i]) begin bad++; $display("FAIL decode_lane%0d: got %h want %h", i, hex_s[8*i +: 8], exp[i]); end
      end
      value_s = 24'hFFFFFF; dots_s = '1;
      step();
      total++; if (hex_s !== 48'hC0C0_88B0_0EF9) begin bad++; $display("FAIL decode_hold: got %h want C0C088B00EF9", hex_s); end
      $display("test_decode done");
   endtask

   task automatic test_blank_lz();
      logic [7:0] exp [6] = '{8'hC0, 8'hC0, 8'hA4, 8'hC0, 8'hF9, 8'hFF};
      blz_s = 1'b1;
      step();
      total++; if (hex_s !== 48'hFFFF_88B0_0EF9) begin bad++; $display("FAIL lz_live: got %h want FFFF88B00EF9", hex_s); end
      value_s = 24'h000000; dots_s = 6'b000000; load_s = 1'b1; step(); load_s = 1'b0; step();
      total++; if (hex_s !== 48'hFFFF_FFFF_FFC0) begin bad++; $display("FAIL lz_zero: got %h want FFFFFFFFFFC0", hex_s); end
      dots_s = 6'b000010; load_s = 1'b1; step(); load_s = 1'b0; step();
      total++; if (hex_s !== 48'hFFFF_FFFF_7FC0) begin bad++; $display("FAIL lz_dot: got %h want FFFFFFFF7FC0", hex_s); end
      value_s = 24'h010200; dots_s = '0; load_s = 1'b1; step(); load_s = 1'b0; step();
      for (int i = 0; i < 6; i++) begin
         total++;
         if (hex_s[8*i +: 8] !== exp[i]) begin bad++; $display("FAIL lz_inner_lane%0d: got %h want %h", i, hex_s[8*i +: 8], exp[i]); end
      end
      blz_s = 1'b0;
      step();
      total++; if (hex_s[47:40] !== 8'hC0) begin bad++; $display("FAIL lz_off: got %h want C0", hex_s[47:40]); end
      $display("test_blank_lz done");
   endtask

   task automatic test_back_to_back();
      dots_s = '0; blink_s = '0; blz_s = 1'b0;
      value_s = 24'h000005; load_s = 1'b1; step();
      value_s = 24'h00000E; step();
      load_s = 1'b0;
      total++; if (hex_s[7:0] !== 8'h92) begin bad++; $display("FAIL b2b_first: got %h want 92", hex_s[7:0]); end
      step();
      total++; if (hex_s[7:0] !== 8'h86) begin bad++; $display("FAIL b2b_second: got %h want 86", hex_s[7:0]); end
      $display("test_back_to_back done");
   endtask

   task automatic test_blink();
      logic [7:0] want;
      rst_s = 1'b0; step();
      rst_s = 1'b1; value_s = 24'h000001; blink_s = 6'b000001; dots_s = '0; blz_s = 1'b0; load_s = 1'b1;
      step();
      load_s = 1'b0;
      total++; if (hex_s[7:0] !== 8'hC0) begin bad++; $display("FAIL blink_n1: got %h want C0", hex_s[7:0]); end
      for (int n = 2; n <= 21; n++) begin
         load_s = (n == 10);
         step();
         want = (((n - 1) / 4) % 2 == 0) ? 8'hF9 : 8'hFF;
         total++;
         if (hex_s[7:0] !== want) begin bad++; $display("FAIL blink_lane0_n%0d: got %h want %h", n, hex_s[7:0], want); end
         total++;
         if (hex_s[15:8] !== 8'hC0) begin bad++; $display("FAIL blink_lane1_n%0d: got %h want C0", n, hex_s[15:8]); end
      end
      load_s = 1'b0;
      $display("test_blink done");
   endtask

   task automatic test_scan();
      logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [7:0] g_tab [4]   = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
      int idx;
      rst_m = 1'b0; step();
      total++; if (sel_m !== 4'b1111 || hex_m !== {32{1'b1}}) begin bad++; $display("FAIL scan_reset: got sel %b hex %h want 1111 all FF", sel_m, hex_m); end
      rst_m = 1'b1; value_m = 16'h4321; dots_m = '0; blink_m = '0; blz_m = 1'b0; load_m = 1'b1;
      step();
      load_m = 1'b0;
      total++; if (sel_m !== 4'b1110 || hex_m[7:0] !== 8'hC0) begin bad++; $display("FAIL scan_n1: got sel %b lane0 %h want 1110 C0", sel_m, hex_m[7:0]); end
      for (int n = 2; n <= 17; n++) begin
         step();
         idx = ((n - 1) / 2) % 4;
         total++;
         if (sel_m !== sel_tab[idx]) begin bad++; $display("FAIL scan_sel_n%0d: got %b want %b", n, sel_m, sel_tab[idx]); end
         total++;
         if (hex_m[7:0] !== g_tab[idx]) begin bad++; $display("FAIL scan_lane0_n%0d: got %h want %h", n, hex_m[7:0], g_tab[idx]); end
         total++;
         if (hex_m[31:8] !== 24'hFFFFFF) begin bad++; $display("FAIL scan_upper_n%0d: got %h want FFFFFF", n, hex_m[31:8]); end
      end
      $display("test_scan done");
   endtask

   task automatic test_scan_reset();
      rst_m = 1'b0; step();
      rst_m = 1'b1; value_m = 16'h4321; blink_m = 4'b0100; load_m = 1'b1;
      step();
      load_m = 1'b0;
      repeat (4) step();
      total++; if (sel_m !== 4'b1011 || hex_m[7:0] !== 8'hFF) begin bad++; $display("FAIL scanrst_blinkoff: got sel %b lane0 %h want 1011 FF", sel_m, hex_m[7:0]); end
      rst_m = 1'b0; step();
      total++; if (sel_m !== 4'b1111 || hex_m !== {32{1'b1}}) begin bad++; $display("FAIL scanrst_mid: got sel %b hex %h want 1111 all FF", sel_m, hex_m); end
      rst_m = 1'b1; blink_m = 4'b0001; load_m = 1'b1;
      step();
      load_m = 1'b0;
      total++; if (sel_m !== 4'b1110 || hex_m[7:0] !== 8'hC0) begin bad++; $display("FAIL scanrst_n1: got sel %b lane0 %h want 1110 C0", sel_m, hex_m[7:0]); end
      step();
      total++; if (sel_m !== 4'b1110 || hex_m[7:0] !== 8'hF9) begin bad++; $display("FAIL scanrst_n2: got sel %b lane0 %h want 1110 F9", sel_m, hex_m[7:0]); end
      step();
      total++; if (sel_m !== 4'b1101 || hex_m[7:0] !== 8'hA4) begin bad++; $display("FAIL scanrst_n3: got sel %b lane0 %h want 1101 A4", sel_m, hex_m[7:0]); end
      $display("test_scan_reset done");
   endtask

   initial begin
      test_reset();
      test_decode();
      test_blank_lz();
      test_back_to_back();
      test_blink();
      test_scan();
      test_scan_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
